// File: rtl/multi_channel_sensor_pio.sv
// Multi-channel input PIO: Avalon-MM slave with per-bit input synchronisers, per-channel change
// detection (W1C EDGE), maskable level IRQ. Define SENSOR_PIO_SNAPSHOT_EN for coherent DATA snapshots.
module multi_channel_sensor_pio #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic [31:0]              readdata,
  output logic                     irq
);

  localparam int BUS_W = NUM_CH * DATA_W;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_MAX   = ARM_W'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] EDGE_ADDR = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(NUM_CH + 1);

  logic [BUS_W-1:0]  sync_q [SYNC_STAGES];
  logic [BUS_W-1:0]  sync_bus;
  logic [BUS_W-1:0]  prev_q;
  logic [BUS_W-1:0]  data_bus;
  logic [ARM_W-1:0]  arm_cnt;
  logic              armed;
  logic              wr_en;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] change;
  logic [NUM_CH-1:0] clr;
  logic [31:0]       rd_mux;
  logic              unused_writedata;

  assign sync_bus         = sync_q[SYNC_STAGES-1];
  assign armed            = (arm_cnt == ARM_MAX);
  assign wr_en            = chipselect & ~write_n;
  assign unused_writedata = ^writedata[31:NUM_CH];

  // NOTE: every flop of the synchroniser array is reset, not just the last stage, so a
  // reset mid-operation cannot leave stale bits that later look like a channel change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage sample its predecessor's old value,
      // which is what makes this a shift chain rather than a single flop.
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_bus;
    end
  end

  // Detection stays off until the synchroniser and prev flops hold real input values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
  end

  always_comb begin
    // NOTE: defaults at the top of every always_comb keep unassigned paths from inferring latches.
    change = '0;
    for (int k = 0; k < NUM_CH; k++)
      change[k] = armed && (sync_bus[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
    clr = (wr_en && address == EDGE_ADDR) ? writedata[NUM_CH-1:0] : '0;
  end

  // Set has priority over a same-cycle W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~clr) | change;
      if (wr_en && address == MASK_ADDR) mask_q <= writedata[NUM_CH-1:0];
      irq <= |(edge_q & mask_q);
    end
  end

`ifdef SENSOR_PIO_SNAPSHOT_EN
  localparam logic [ADDR_W-1:0] SNAP_ADDR = ADDR_W'(NUM_CH + 2);
  logic [BUS_W-1:0] snap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            snap_q <= '0;
    else if (wr_en && address == SNAP_ADDR)  snap_q <= sync_bus;
  end

  assign data_bus = snap_q;
`else
  assign data_bus = sync_bus;
`endif

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (address == ADDR_W'(k)) rd_mux = 32'(data_bus[k*DATA_W +: DATA_W]);
    if (address == EDGE_ADDR) rd_mux = 32'(edge_q);
    if (address == MASK_ADDR) rd_mux = 32'(mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_multi_channel_sensor_pio.sv
// Directed self-checking bench for multi_channel_sensor_pio (default parameters).
// Snapshot checks follow SENSOR_PIO_SNAPSHOT_EN when it is defined for the build.
module tb_multi_channel_sensor_pio;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] A_EDGE = 3'd4;
  localparam logic [ADDR_W-1:0] A_MASK = 3'd5;
  localparam logic [ADDR_W-1:0] A_SNAP = 3'd6;

  logic                     clk;
  logic                     reset_n;
  logic [ADDR_W-1:0]        address;
  logic                     chipselect;
  logic                     write_n;
  logic [31:0]              writedata;
  logic [NUM_CH*DATA_W-1:0] in_port;
  logic [31:0]              readdata;
  logic                     irq;

  int vectors;
  int miscompares;

  multi_channel_sensor_pio #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    in_port[k*DATA_W +: DATA_W] = v;
  endtask

  // One-cycle Avalon write; returns on the negedge after the write edge.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    logic [31:0] exp_data0;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    in_port     = '0;
    set_ch(0, 16'h1234);

    // 1: reset state, then DATA0 through 2 sync stages plus 1 read register
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);
    check("data0_before_sync", readdata, 32'h0);
    tick(1);
`ifdef SENSOR_PIO_SNAPSHOT_EN
    exp_data0 = 32'h0;
`else
    exp_data0 = 32'h1234;
`endif
    check("data0_after_sync", readdata, exp_data0);
    address = A_EDGE;
    tick(5);
    check("edge_after_powerup", readdata, 32'h0);
    check("irq_after_powerup", {31'b0, irq}, 32'h0);

    // 2: masked change raises irq on the 4th edge; W1C drops it one clk after the write
    wr(A_MASK, 32'h2);
    set_ch(1, 16'h00FF);
    address = A_EDGE;
    tick(3);
    check("t2_irq_edge3", {31'b0, irq}, 32'h0);
    check("t2_edge_edge3", readdata, 32'h0);
    tick(1);
    check("t2_irq_edge4", {31'b0, irq}, 32'h1);
    check("t2_edge_edge4", readdata, 32'h2);
    wr(A_EDGE, 32'h2);
    check("t2_irq_at_clear", {31'b0, irq}, 32'h1);
    tick(1);
    check("t2_irq_after_clear", {31'b0, irq}, 32'h0);
    check("t2_edge_after_clear", readdata, 32'h0);

    // 3: set and W1C clear on the same edge -> set wins
    set_ch(2, 16'h0001);
    tick(3);
    set_ch(2, 16'h0002);
    tick(2);
    wr(A_EDGE, 32'h4);
    tick(1);
    check("t3_set_wins", readdata, 32'h4);
    check("t3_irq_unmasked", {31'b0, irq}, 32'h0);
    wr(A_EDGE, 32'h4);
    tick(1);
    check("t3_edge_cleared", readdata, 32'h0);

    // 4: unmasked change latches EDGE without irq; enabling MASK raises irq one clk later
    wr(A_MASK, 32'h0);
    set_ch(3, 16'hFFFF);
    address = A_EDGE;
    tick(4);
    check("t4_edge3_set", readdata, 32'h8);
    check("t4_irq_masked", {31'b0, irq}, 32'h0);
    wr(A_MASK, 32'hFFFF_FFF8);
    check("t4_irq_at_mask_write", {31'b0, irq}, 32'h0);
    tick(1);
    check("t4_irq_after_mask", {31'b0, irq}, 32'h1);
    address = A_MASK;
    tick(1);
    check("t4_mask_readback", readdata, 32'h8);

    // 5: SNAP register behaviour
    address = A_SNAP;
    tick(1);
    check("t5_snap_reads_zero", readdata, 32'h0);
`ifdef SENSOR_PIO_SNAPSHOT_EN
    set_ch(0, 16'hAAAA);
    tick(2);
    wr(A_SNAP, 32'h0);
    set_ch(0, 16'h5555);
    address = '0;
    tick(4);
    check("t5_snap_held", readdata, 32'hAAAA);
    wr(A_SNAP, 32'h0);
    address = '0;
    tick(1);
    check("t5_snap_updated", readdata, 32'h5555);
`else
    wr(A_SNAP, 32'hFFFF_FFFF);
    tick(1);
    check("t5_snap_write_ignored", readdata, 32'h0);
    set_ch(0, 16'h5555);
    address = '0;
    tick(3);
    check("t5_data0_live", readdata, 32'h5555);
`endif
    address = 3'd7;
    tick(1);
    check("unmapped_reads_zero", readdata, 32'h0);

    // 6: async reset with EDGE=1111 and irq=1; no spurious EDGE after release
    wr(A_MASK, 32'hF);
    set_ch(0, 16'h0F0F);
    set_ch(1, 16'h0000);
    set_ch(2, 16'h00A0);
    set_ch(3, 16'h0000);
    address = A_EDGE;
    tick(5);
    check("t6_edge_all", readdata, 32'hF);
    check("t6_irq_before_reset", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_readdata_async_clear", readdata, 32'h0);
    check("t6_irq_async_clear", {31'b0, irq}, 32'h0);
    set_ch(1, 16'hBEEF);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("t6_irq_after_release", {31'b0, irq}, 32'h0);
    tick(3);
    check("t6_no_spurious_edge", readdata, 32'h0);
    address = A_MASK;
    tick(1);
    check("t6_mask_cleared", readdata, 32'h0);
    set_ch(1, 16'h0001);
    address = A_EDGE;
    tick(4);
    check("t6_rearmed_edge", readdata, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
